// File: rtl/rgb_led_sequencer.sv
// -----------------------------------------------------------------------------
// rgb_led_sequencer
//
// Step-timed pattern engine for NUM_LEDS RGB user LEDs (CH = 3*NUM_LEDS
// channels). Patterns: ROTATE (one-hot walk), FILL (thermometer), BREATHE
// (all channels, triangular intensity ramp) and OFF. Every lit channel is
// gated by a free-running PWM compare against a global duty value.
//
// Ports
//   clk100      in   1         system clock, rising edge
//   rst_n       in   1         asynchronous active-low reset
//   mode        in   2         0 ROTATE, 1 FILL, 2 BREATHE, 3 OFF
//   brightness  in   PWM_BITS  global duty for lit channels
//   pause       in   1         freezes pattern, step prescaler and lvl
//   led_n       out  CH        active-low channel drive, bit 3k+0/1/2 = R/G/B
//   step_pulse  out  1         one-cycle pulse per pattern step
//
// Handshake: none. All inputs are level-sampled every cycle; mode only takes
// effect on a step tick.
//
// Output timing: led_n is registered and is computed from the *next* pattern,
// mode and lvl values, so a pattern step becomes visible on led_n in the same
// cycle that step_pulse is high. pwm_cnt and brightness feed led_n with one
// cycle of latency.
// -----------------------------------------------------------------------------
module rgb_led_sequencer #(
   parameter int NUM_LEDS = 4,
   parameter int PWM_BITS = 8,
   parameter int CLK_HZ   = 100_000_000,
   parameter int STEP_HZ  = 2
) (
   input  logic                  clk100,
   input  logic                  rst_n,
   input  logic [1:0]            mode,
   input  logic [PWM_BITS-1:0]   brightness,
   input  logic                  pause,
   output logic [3*NUM_LEDS-1:0] led_n,
   output logic                  step_pulse
);

   localparam int CH       = 3 * NUM_LEDS;
   localparam int STEP_DIV = CLK_HZ / STEP_HZ;
   localparam int SC_W     = $clog2(STEP_DIV);
   localparam int BDIV_RAW = STEP_DIV >> PWM_BITS;
   localparam int BDIV     = (BDIV_RAW < 1) ? 1 : BDIV_RAW;
   localparam int BD_W     = (BDIV > 1) ? $clog2(BDIV) : 1;

   localparam logic [SC_W-1:0]     STEP_LAST = SC_W'(STEP_DIV - 1);
   localparam logic [BD_W-1:0]     BDIV_LAST = BD_W'(BDIV - 1);
   localparam logic [PWM_BITS-1:0] LVL_MAX   = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] LVL_TOPM1 = LVL_MAX - 1'b1;
   localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);

   typedef enum logic [1:0] {
      MODE_ROTATE  = 2'd0,
      MODE_FILL    = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_OFF     = 2'd3
   } mode_e;

   // Pattern value a mode starts from when it is (re)entered.
   function automatic logic [CH-1:0] init_pat(input mode_e m);
      logic [CH-1:0] p;
      case (m)
         MODE_ROTATE:  p = CH'(1);
         MODE_FILL:    p = CH'(1);
         MODE_BREATHE: p = {CH{1'b1}};
         default:      p = '0;
      endcase
      return p;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [SC_W-1:0]     step_cnt, step_cnt_d;
   logic [PWM_BITS-1:0] pwm_cnt;
   mode_e               mode_q, mode_q_d;
   logic [CH-1:0]       pat, pat_d;
   logic [PWM_BITS-1:0] lvl, lvl_d;
   logic                up, up_d;
   logic [BD_W-1:0]     bdiv_cnt, bdiv_cnt_d;

   // ---------------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------------
   mode_e                 mode_in;
   logic                  tick;
   logic                  mode_change;
   logic                  breathe_adv;
   logic [2*PWM_BITS-1:0] prod;
   logic [PWM_BITS-1:0]   duty;
   logic                  pwm_hit;
   logic [CH-1:0]         on;

   assign mode_in = mode_e'(mode);

   always_comb begin
      step_cnt_d  = step_cnt;
      mode_q_d    = mode_q;
      pat_d       = pat;
      lvl_d       = lvl;
      up_d        = up;
      bdiv_cnt_d  = bdiv_cnt;
      prod        = '0;
      duty        = brightness;
      pwm_hit     = 1'b0;
      on          = '0;

      tick        = (step_cnt == STEP_LAST) && !pause;
      mode_change = tick && (mode_in != mode_q);
      breathe_adv = (mode_q == MODE_BREATHE) && !pause && (bdiv_cnt == BDIV_LAST);

      // Prescaler: holds while paused, so a suppressed tick fires as soon as
      // pause drops.
      if (!pause) begin
         step_cnt_d = tick ? '0 : step_cnt + 1'b1;
      end

      if (tick) begin
         mode_q_d = mode_in;
      end

      // Pattern: a newly selected mode restarts from its initial value rather
      // than stepping the old pattern.
      if (mode_change) begin
         pat_d = init_pat(mode_in);
      end else if (tick) begin
         case (mode_q)
            MODE_ROTATE:  pat_d = {pat[CH-2:0], pat[CH-1]};
            MODE_FILL:    pat_d = (pat == {CH{1'b1}}) ? CH'(1) : {pat[CH-2:0], 1'b1};
            MODE_BREATHE: pat_d = {CH{1'b1}};
            default:      pat_d = '0;
         endcase
      end

      // Breathe ramp. The direction flips on the same advance that reaches an
      // end point, so lvl never leaves 0..LVL_MAX and a full cycle is
      // 2*LVL_MAX advances.
      if (mode_change) begin
         lvl_d      = '0;
         up_d       = 1'b1;
         bdiv_cnt_d = '0;
      end else begin
         if (!pause) begin
            bdiv_cnt_d = (bdiv_cnt == BDIV_LAST) ? '0 : bdiv_cnt + 1'b1;
         end
         if (breathe_adv) begin
            if (up) begin
               lvl_d = lvl + 1'b1;
               if (lvl == LVL_TOPM1) up_d = 1'b0;
            end else begin
               lvl_d = lvl - 1'b1;
               if (lvl == LVL_ONE) up_d = 1'b1;
            end
         end
      end

      // Duty follows the mode/lvl that will be live after this edge.
      if (mode_q_d == MODE_BREATHE) begin
         prod = {{PWM_BITS{1'b0}}, brightness} * {{PWM_BITS{1'b0}}, lvl_d};
         duty = prod[2*PWM_BITS-1:PWM_BITS];
      end

      // Full-scale duty is treated as always-on; otherwise one PWM slot per
      // period would stay dark.
      pwm_hit = (pwm_cnt < duty) || (duty == LVL_MAX);
      on      = pat_d & {CH{pwm_hit}};
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         step_cnt   <= '0;
         pwm_cnt    <= '0;
         mode_q     <= MODE_ROTATE;
         pat        <= CH'(1);
         lvl        <= '0;
         up         <= 1'b1;
         bdiv_cnt   <= '0;
         led_n      <= {CH{1'b1}};
         step_pulse <= 1'b0;
      end else begin
         step_cnt   <= step_cnt_d;
         pwm_cnt    <= pwm_cnt + 1'b1;
         mode_q     <= mode_q_d;
         pat        <= pat_d;
         lvl        <= lvl_d;
         up         <= up_d;
         bdiv_cnt   <= bdiv_cnt_d;
         led_n      <= ~on;
         step_pulse <= tick;
      end
   end

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rgb_led_sequencer
//
// Bench for rgb_led_sequencer with NUM_LEDS=1, PWM_BITS=4, CLK_HZ=1000,
// STEP_HZ=100 (STEP_DIV=10, CH=3, BDIV=1). The reference model tracks the
// number of steps and breathe advances since the current mode was entered and
// derives the pattern and intensity from those counts arithmetically.
// -----------------------------------------------------------------------------
module tb_rgb_led_sequencer;

   logic       clk100;
   logic       rst_n;
   logic [1:0] mode;
   logic [3:0] brightness;
   logic       pause;
   logic [2:0] led_n;
   logic       step_pulse;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   // Reference model state
   int   m_cnt, m_pwm, m_mode, m_steps, m_badv;
   logic [2:0] exp_led;
   logic       exp_pulse;

   rgb_led_sequencer #(
      .NUM_LEDS (1),
      .PWM_BITS (4),
      .CLK_HZ   (1000),
      .STEP_HZ  (100)
   ) dut (
      .clk100     (clk100),
      .rst_n      (rst_n),
      .mode       (mode),
      .brightness (brightness),
      .pause      (pause),
      .led_n      (led_n),
      .step_pulse (step_pulse)
   );

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   initial clk100 = 1'b0;
   always #5 clk100 = ~clk100;

   task automatic model_reset();
      m_cnt     = 0;
      m_pwm     = 0;
      m_mode    = 0;
      m_steps   = 0;
      m_badv    = 0;
      exp_led   = 3'b111;
      exp_pulse = 1'b0;
   endtask

   // Expected led_n from the step/advance counts since the mode was entered.
   function automatic logic [2:0] model_led(input int pwm_before);
      int pat, p, lvl, duty;
      bit hit;
      case (m_mode)
         0:       pat = 1 << (m_steps % 3);
         1:       pat = (1 << ((m_steps % 3) + 1)) - 1;
         2:       pat = 7;
         default: pat = 0;
      endcase
      p    = m_badv % 30;
      lvl  = (p <= 15) ? p : 30 - p;
      duty = (m_mode == 2) ? (int'(brightness) * lvl) / 16 : int'(brightness);
      hit  = (pwm_before < duty) || (duty == 15);
      return hit ? ~3'(pat) : 3'b111;
   endfunction

   task automatic model_update();
      int pwm_before;
      bit tk;
      pwm_before = m_pwm;
      tk = (m_cnt == 9) && !pause;
      if (tk && int'(mode) != m_mode) begin
         m_mode  = int'(mode);
         m_steps = 0;
         m_badv  = 0;
      end else begin
         if (tk) m_steps++;
         if (m_mode == 2 && !pause) m_badv++;
      end
      if (!pause) m_cnt = (m_cnt == 9) ? 0 : m_cnt + 1;
      m_pwm     = (m_pwm + 1) % 16;
      exp_led   = model_led(pwm_before);
      exp_pulse = tk;
   endtask

   // One clock: advance the model at the edge, leave time at edge+1 for sampling.
   task automatic clk_step();
      @(posedge clk100);
      if (!rst_n) model_reset();
      else model_update();
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk100);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk100);
      rst_n = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0; mode = 2'd0; brightness = 4'd15; pause = 1'b0;
      model_reset();
      repeat (3) clk_step();
      vectors++;
      if (led_n !== 3'b111) begin
         errors++; $display("FAIL reset_led_n: got %b expected %b", led_n, 3'b111);
      end
      vectors++;
      if (step_pulse !== 1'b0) begin
         errors++; $display("FAIL reset_step_pulse: got %b expected 0", step_pulse);
      end
      @(negedge clk100);
      rst_n = 1'b1;
   endtask

   task automatic test_rotate();
      logic [2:0] seq [4];
      int np;
      seq = '{3'b101, 3'b011, 3'b110, 3'b101};
      np = 0;
      mode = 2'd0; brightness = 4'd15; pause = 1'b0;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         clk_step();
         vectors++;
         if (led_n !== exp_led || step_pulse !== exp_pulse) begin
            errors++;
            $display("FAIL rotate_model cyc %0d: got %b/%b expected %b/%b", i, led_n, step_pulse, exp_led, exp_pulse);
         end
         if (step_pulse === 1'b1 && np < 4) begin
            vectors++;
            if (led_n !== seq[np]) begin
               errors++; $display("FAIL rotate_step%0d: got %b expected %b", np, led_n, seq[np]);
            end
            np++;
         end
      end
      vectors++;
      if (np != 4) begin
         errors++; $display("FAIL rotate_pulse_count: got %0d expected 4", np);
      end
   endtask

   task automatic test_fill();
      logic [2:0] seq [4];
      int np;
      seq = '{3'b110, 3'b100, 3'b000, 3'b110};
      np = 0;
      mode = 2'd1; brightness = 4'd15; pause = 1'b0;
      do_reset();
      for (int i = 0; i < 45; i++) begin
         clk_step();
         vectors++;
         if (led_n !== exp_led || step_pulse !== exp_pulse) begin
            errors++;
            $display("FAIL fill_model cyc %0d: got %b/%b expected %b/%b", i, led_n, step_pulse, exp_led, exp_pulse);
         end
         if (step_pulse === 1'b1 && np < 4) begin
            vectors++;
            if (led_n !== seq[np]) begin
               errors++; $display("FAIL fill_step%0d: got %b expected %b", np, led_n, seq[np]);
            end
            np++;
         end
      end
      vectors++;
      if (np != 4) begin
         errors++; $display("FAIL fill_pulse_count: got %0d expected 4", np);
      end
   endtask

   task automatic test_pwm();
      int lit0, lit_other;
      lit0 = 0; lit_other = 0;
      mode = 2'd0; brightness = 4'd4; pause = 1'b1;
      do_reset();
      for (int i = 0; i < 32; i++) begin
         clk_step();
         vectors++;
         if (led_n !== exp_led) begin
            errors++; $display("FAIL pwm4_model cyc %0d: got %b expected %b", i, led_n, exp_led);
         end
         if (led_n[0] === 1'b0) lit0++;
         if (led_n[2:1] !== 2'b11) lit_other++;
      end
      vectors++;
      if (lit0 != 8) begin
         errors++; $display("FAIL pwm4_duty: got %0d lit of 32 expected 8", lit0);
      end
      vectors++;
      if (lit_other != 0) begin
         errors++; $display("FAIL pwm4_other_bits: got %0d lit cycles expected 0", lit_other);
      end
      brightness = 4'd0;
      clk_step();
      for (int i = 0; i < 16; i++) begin
         clk_step();
         vectors++;
         if (led_n !== 3'b111) begin
            errors++; $display("FAIL pwm0_dark cyc %0d: got %b expected 111", i, led_n);
         end
      end
      pause = 1'b0;
   endtask

   task automatic test_pause();
      int t_prev, t_next, guard;
      logic [2:0] frozen;
      mode = 2'd0; brightness = 4'd15; pause = 1'b0;
      do_reset();
      t_prev = -1;
      for (guard = 0; guard < 30 && t_prev < 0; guard++) begin
         clk_step();
         if (step_pulse === 1'b1) t_prev = cyc;
      end
      vectors++;
      if (t_prev < 0) begin
         errors++; $display("FAIL pause_first_pulse: got none expected one within 30 cycles");
      end
      repeat (3) clk_step();
      pause  = 1'b1;
      frozen = exp_led;
      for (int i = 0; i < 25; i++) begin
         clk_step();
         vectors++;
         if (step_pulse !== 1'b0 || led_n !== frozen) begin
            errors++;
            $display("FAIL pause_frozen cyc %0d: got %b/%b expected %b/0", i, led_n, step_pulse, frozen);
         end
      end
      pause  = 1'b0;
      t_next = -1;
      for (guard = 0; guard < 40 && t_next < 0; guard++) begin
         clk_step();
         if (step_pulse === 1'b1) t_next = cyc;
      end
      vectors++;
      if (t_next - t_prev != 35) begin
         errors++; $display("FAIL pause_interval: got %0d expected 35", t_next - t_prev);
      end
      vectors++;
      if (led_n !== 3'b011) begin
         errors++; $display("FAIL pause_resume_pattern: got %b expected 011", led_n);
      end
   endtask

   task automatic test_breathe();
      mode = 2'd2; brightness = 4'd15; pause = 1'b0;
      do_reset();
      repeat (10) clk_step();
      vectors++;
      if (step_pulse !== 1'b1 || led_n !== 3'b111) begin
         errors++; $display("FAIL breathe_entry: got %b/%b expected 111/1", led_n, step_pulse);
      end
      for (int i = 0; i < 70; i++) begin
         clk_step();
         vectors++;
         if (led_n !== exp_led || step_pulse !== exp_pulse) begin
            errors++;
            $display("FAIL breathe_model cyc %0d: got %b/%b expected %b/%b", i, led_n, step_pulse, exp_led, exp_pulse);
         end
      end
   endtask

   task automatic test_mode_switch();
      int np, guard;
      np = 0;
      mode = 2'd1; brightness = 4'd15; pause = 1'b0;
      do_reset();
      for (guard = 0; guard < 60 && np < 3; guard++) begin
         clk_step();
         vectors++;
         if (led_n !== exp_led) begin
            errors++; $display("FAIL switch_model cyc %0d: got %b expected %b", guard, led_n, exp_led);
         end
         if (step_pulse === 1'b1) begin
            np++;
            if (np == 2) mode = 2'd0;
            if (np == 3) begin
               vectors++;
               if (led_n !== 3'b110) begin
                  errors++; $display("FAIL switch_restart: got %b expected 110", led_n);
               end
            end
         end
      end
      vectors++;
      if (np != 3) begin
         errors++; $display("FAIL switch_pulse_count: got %0d expected 3", np);
      end
      repeat (4) clk_step();
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (led_n !== 3'b111 || step_pulse !== 1'b0) begin
         errors++; $display("FAIL async_reset: got %b/%b expected 111/0", led_n, step_pulse);
      end
      @(negedge clk100);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      mode = 2'd0; brightness = 4'($urandom_range(0, 15)); pause = 1'b0;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         clk_step();
         vectors++;
         if (led_n !== exp_led || step_pulse !== exp_pulse) begin
            errors++;
            $display("FAIL random_model cyc %0d: got %b/%b expected %b/%b", i, led_n, step_pulse, exp_led, exp_pulse);
         end
         if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 19) == 0) brightness = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) pause = ~pause;
      end
      pause = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_rotate();
      test_fill();
      test_pwm();
      test_pause();
      test_breathe();
      test_mode_switch();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
